// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned PERF_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_D    = 2'd1,
    GNT_I    = 2'd2
  } arb_grant_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data access; stalls the pipeline until both complete.
// Optional performance counters are enabled with MEM_ARB_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                mem_stall
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0]   perf_stall_cycles,
  output logic [PERF_W-1:0]   perf_accesses
`endif
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_e        r_state;
  arb_state_e        w_next;
  arb_grant_e        w_grant;
  logic              r_dm_done;
  logic              r_if_done;
  logic [DATA_W-1:0] r_dm_rdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic              w_dm_pend;
  logic              w_if_pend;
  logic              w_ack_d;
  logic              w_ack_i;

  assign w_dm_pend = dm_req & ~r_dm_done;
  assign w_if_pend = if_req & ~r_if_done;
  assign mem_stall = w_dm_pend | w_if_pend;

  // Grant is free in IDLE and locked to the owner while an access waits for ack.
  always_comb begin
    w_grant   = GNT_NONE;
    w_next    = r_state;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_be    = '0;
    bus_addr  = '0;
    bus_wdata = '0;

    case (r_state)
      IDLE: begin
        if (w_dm_pend)      w_grant = GNT_D;
        else if (w_if_pend) w_grant = GNT_I;
      end
      BUSY_D:  w_grant = GNT_D;
      BUSY_I:  w_grant = GNT_I;
      default: w_grant = GNT_NONE;
    endcase

    case (w_grant)
      GNT_D: begin
        bus_req   = 1'b1;
        bus_we    = dm_we;
        bus_be    = dm_be;
        bus_addr  = dm_addr;
        bus_wdata = dm_wdata;
      end
      GNT_I: begin
        bus_req  = 1'b1;
        bus_be   = {BE_W{1'b1}};
        bus_addr = if_addr;
      end
      default: ;
    endcase

    case (r_state)
      IDLE: begin
        if (!bus_ack) begin
          if (w_grant == GNT_D)      w_next = BUSY_D;
          else if (w_grant == GNT_I) w_next = BUSY_I;
        end
      end
      BUSY_D, BUSY_I: begin
        if (bus_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_ack_d = bus_ack & (w_grant == GNT_D);
  assign w_ack_i = bus_ack & (w_grant == GNT_I);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dm_done  <= 1'b0;
      r_if_done  <= 1'b0;
      r_dm_rdata <= '0;
      r_if_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_ack_d && !dm_we) r_dm_rdata <= bus_rdata;
      if (w_ack_i)           r_if_rdata <= bus_rdata;
      // A source that dropped its request mid-access gets its data but no done flag.
      if (!mem_stall) begin
        r_dm_done <= 1'b0;
        r_if_done <= 1'b0;
      end else begin
        if (w_ack_d && dm_req) r_dm_done <= 1'b1;
        if (w_ack_i && if_req) r_if_done <= 1'b1;
      end
    end
  end

  assign dm_rdata = r_dm_rdata;
  assign if_rdata = r_if_rdata;

`ifdef MEM_ARB_PERF_EN
  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_acc   <= '0;
    end else begin
      if (mem_stall)            r_perf_stall <= r_perf_stall + PERF_W'(1);
      if (w_ack_d || w_ack_i)   r_perf_acc   <= r_perf_acc + PERF_W'(1);
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_accesses     = r_perf_acc;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (build with MEM_ARB_PERF_EN to cover the counters).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        mem_stall;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_accesses;
`endif

  int n_pass;
  int n_total;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .mem_stall(mem_stall)
`ifdef MEM_ARB_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_accesses(perf_accesses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dreq, dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr, dwd;
    logic        ireq;
    logic [31:0] iaddr;
    logic        ack;
    logic [31:0] rdata;
    logic        stall, breq, bwe;
    logic [3:0]  bbe;
    logic [31:0] baddr, bwd, dmr, ifr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic dreq, logic dwe, logic [3:0] dbe, logic [31:0] daddr,
                              logic [31:0] dwd, logic ireq, logic [31:0] iaddr, logic ack,
                              logic [31:0] rdata, logic stall, logic breq, logic bwe,
                              logic [3:0] bbe, logic [31:0] baddr, logic [31:0] bwd,
                              logic [31:0] dmr, logic [31:0] ifr);
    vec_t v;
    v.dreq = dreq; v.dwe = dwe; v.dbe = dbe; v.daddr = daddr; v.dwd = dwd;
    v.ireq = ireq; v.iaddr = iaddr; v.ack = ack; v.rdata = rdata;
    v.stall = stall; v.breq = breq; v.bwe = bwe; v.bbe = bbe;
    v.baddr = baddr; v.bwd = bwd; v.dmr = dmr; v.ifr = ifr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle of inputs (load-style byte enables and zero write data).
  task automatic drive(input logic dreq, input logic [31:0] daddr, input logic ireq,
                       input logic [31:0] iaddr, input logic ack, input logic [31:0] rdata);
    dm_req = dreq; dm_we = 1'b0; dm_be = 4'hF; dm_addr = daddr; dm_wdata = 32'h0;
    if_req = ireq; if_addr = iaddr; bus_ack = ack; bus_rdata = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, single load, load+fetch (immediate and with a wait), 3-wait store, fetch, ack with no request.
    vecs.push_back(mk(0,0,4'h0,32'h0,  32'h0,      0,32'h0,0,32'h0,      0,0,0,4'h0,32'h0,  32'h0,      32'h0,      32'h0));
    vecs.push_back(mk(1,0,4'hF,32'h100,32'h0,      0,32'h0,1,32'hCAFEF00D,1,1,0,4'hF,32'h100,32'h0,     32'h0,      32'h0));
    vecs.push_back(mk(1,0,4'hF,32'h100,32'h0,      0,32'h0,0,32'h0,      0,0,0,4'h0,32'h0,  32'h0,      32'hCAFEF00D,32'h0));
    vecs.push_back(mk(1,0,4'hF,32'h200,32'h0,      1,32'h4,1,32'hAAAA0001,1,1,0,4'hF,32'h200,32'h0,     32'hCAFEF00D,32'h0));
    vecs.push_back(mk(1,0,4'hF,32'h200,32'h0,      1,32'h4,1,32'h13,     1,1,0,4'hF,32'h4,  32'h0,      32'hAAAA0001,32'h0));
    vecs.push_back(mk(1,0,4'hF,32'h200,32'h0,      1,32'h4,0,32'h0,      0,0,0,4'h0,32'h0,  32'h0,      32'hAAAA0001,32'h13));
    vecs.push_back(mk(1,0,4'hF,32'h200,32'h0,      1,32'h4,0,32'h0,      1,1,0,4'hF,32'h200,32'h0,      32'hAAAA0001,32'h13));
    vecs.push_back(mk(1,0,4'hF,32'h200,32'h0,      1,32'h4,1,32'h55,     1,1,0,4'hF,32'h200,32'h0,      32'hAAAA0001,32'h13));
    vecs.push_back(mk(1,0,4'hF,32'h200,32'h0,      1,32'h4,1,32'h77,     1,1,0,4'hF,32'h4,  32'h0,      32'h55,     32'h13));
    vecs.push_back(mk(1,0,4'hF,32'h200,32'h0,      1,32'h4,0,32'h0,      0,0,0,4'h0,32'h0,  32'h0,      32'h55,     32'h77));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,1,4'h3,32'h300,32'h12345678,0,32'h0,0,32'h0,   1,1,1,4'h3,32'h300,32'h12345678,32'h55,  32'h77));
    vecs.push_back(mk(1,1,4'h3,32'h300,32'h12345678,0,32'h0,1,32'hDEADBEEF,1,1,1,4'h3,32'h300,32'h12345678,32'h55,32'h77));
    vecs.push_back(mk(1,1,4'h3,32'h300,32'h12345678,0,32'h0,0,32'h0,     0,0,0,4'h0,32'h0,  32'h0,      32'h55,     32'h77));
    vecs.push_back(mk(0,0,4'h0,32'h0,  32'h0,      1,32'h8,1,32'h11,     1,1,0,4'hF,32'h8,  32'h0,      32'h55,     32'h77));
    vecs.push_back(mk(0,0,4'h0,32'h0,  32'h0,      1,32'h8,1,32'h99,     0,0,0,4'h0,32'h0,  32'h0,      32'h55,     32'h11));
    vecs.push_back(mk(0,0,4'h0,32'h0,  32'h0,      0,32'h0,0,32'h0,      0,0,0,4'h0,32'h0,  32'h0,      32'h55,     32'h11));

    foreach (vecs[i]) begin
      dm_req = vecs[i].dreq; dm_we = vecs[i].dwe; dm_be = vecs[i].dbe;
      dm_addr = vecs[i].daddr; dm_wdata = vecs[i].dwd;
      if_req = vecs[i].ireq; if_addr = vecs[i].iaddr;
      bus_ack = vecs[i].ack; bus_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d mem_stall", i), 32'(mem_stall), 32'(vecs[i].stall));
      chk($sformatf("v%0d bus_req", i),   32'(bus_req),   32'(vecs[i].breq));
      chk($sformatf("v%0d bus_we", i),    32'(bus_we),    32'(vecs[i].bwe));
      chk($sformatf("v%0d bus_be", i),    32'(bus_be),    32'(vecs[i].bbe));
      chk($sformatf("v%0d bus_addr", i),  bus_addr,       vecs[i].baddr);
      chk($sformatf("v%0d bus_wdata", i), bus_wdata,      vecs[i].bwd);
      chk($sformatf("v%0d dm_rdata", i),  dm_rdata,       vecs[i].dmr);
      chk($sformatf("v%0d if_rdata", i),  if_rdata,       vecs[i].ifr);
      next_cycle();
    end

    // Grant lock: data request arriving during a waiting fetch must not steal the bus.
    drive(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
    @(negedge clk); chk("lock idle addr", bus_addr, 32'h40);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h500, 1'b1, 32'h40, 1'b0, 32'h0);
      @(negedge clk); chk("lock wait addr", bus_addr, 32'h40); chk("lock wait stall", 32'(mem_stall), 32'h1);
      next_cycle();
    end
    drive(1'b1, 32'h500, 1'b1, 32'h40, 1'b1, 32'h1234);
    @(negedge clk); chk("lock ack addr", bus_addr, 32'h40);
    next_cycle();
    drive(1'b1, 32'h500, 1'b1, 32'h40, 1'b1, 32'h5678);
    @(negedge clk); chk("lock data addr", bus_addr, 32'h500); chk("lock if_rdata", if_rdata, 32'h1234);
    next_cycle();
    drive(1'b1, 32'h500, 1'b1, 32'h40, 1'b0, 32'h0);
    @(negedge clk); chk("lock end stall", 32'(mem_stall), 32'h0); chk("lock dm_rdata", dm_rdata, 32'h5678);
    next_cycle();

    // Fetch request dropped while locked: data still captured, done flag not set.
    drive(1'b0, 32'h0, 1'b1, 32'h60, 1'b0, 32'h0);
    @(negedge clk); chk("drop busy addr", bus_addr, 32'h60);
    next_cycle();
    drive(1'b1, 32'h600, 1'b0, 32'h60, 1'b1, 32'hBB);
    @(negedge clk); chk("drop held req", 32'(bus_req), 32'h1); chk("drop held addr", bus_addr, 32'h60);
    next_cycle();
    drive(1'b1, 32'h600, 1'b0, 32'h60, 1'b1, 32'hCC);
    @(negedge clk); chk("drop if_rdata", if_rdata, 32'hBB); chk("drop data addr", bus_addr, 32'h600);
    next_cycle();
    drive(1'b1, 32'h600, 1'b1, 32'h60, 1'b0, 32'h0);
    @(negedge clk); chk("drop no done stall", 32'(mem_stall), 32'h1); chk("drop refetch addr", bus_addr, 32'h60);
    next_cycle();
    drive(1'b1, 32'h600, 1'b1, 32'h60, 1'b1, 32'hDD);
    next_cycle();
    drive(1'b1, 32'h600, 1'b1, 32'h60, 1'b0, 32'h0);
    @(negedge clk); chk("drop end stall", 32'(mem_stall), 32'h0); chk("drop dm_rdata", dm_rdata, 32'hCC);
    next_cycle();

    // Reset in the second wait cycle of a fetch.
    drive(1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 32'h0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk); chk("rst pre bus_req", 32'(bus_req), 32'h1);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rst bus_req", 32'(bus_req), 32'h0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst mem_stall", 32'(mem_stall), 32'h0);
    chk("rst if_rdata", if_rdata, 32'h0);
    chk("rst dm_rdata", dm_rdata, 32'h0);
    next_cycle();

    // Load plus fetch after reset: IDLE grant order and cleared done flags.
    drive(1'b1, 32'h200, 1'b1, 32'h4, 1'b1, 32'h1);
    @(negedge clk); chk("post addr d", bus_addr, 32'h200); chk("post stall0", 32'(mem_stall), 32'h1);
    next_cycle();
    drive(1'b1, 32'h200, 1'b1, 32'h4, 1'b1, 32'h2);
    @(negedge clk); chk("post addr i", bus_addr, 32'h4); chk("post stall1", 32'(mem_stall), 32'h1);
    next_cycle();
    drive(1'b1, 32'h200, 1'b1, 32'h4, 1'b0, 32'h0);
    @(negedge clk);
    chk("post stall2", 32'(mem_stall), 32'h0);
    chk("post dm_rdata", dm_rdata, 32'h1);
    chk("post if_rdata", if_rdata, 32'h2);
`ifdef MEM_ARB_PERF_EN
    chk("perf_stall_cycles", perf_stall_cycles, 32'd2);
    chk("perf_accesses", perf_accesses, 32'd2);
`endif
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
